// File: rtl/seg_cmd_sequencer.sv
// Bus master that walks a 4-bit command range and writes each command to the
// seven-segment peripheral, pacing itself on a programmable interval or on STEP.
module seg_cmd_sequencer #(
    parameter logic [7:0]  SEG_ADDR       = 8'hD0,
    parameter int unsigned INTERVAL       = 25_000_000,
    parameter int unsigned INTERVAL_WIDTH = 25,
    parameter logic [3:0]  CMD_FIRST      = 4'h0,
    parameter logic [3:0]  CMD_LAST       = 4'hF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       STEP,
    input  logic       BUS_GNT,
    output logic       BUS_REQ,
    output logic [7:0] BUS_ADDR,
    output logic [7:0] BUS_DATA,
    output logic       BUS_WE,
    output logic [3:0] CMD_OUT,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WRITE,
        RELEASE
    } state_t;

    state_t state, state_next;

    logic                      step_q;
    logic                      pending, pending_next;
    logic [INTERVAL_WIDTH-1:0] counter, counter_next;
    logic [3:0]                cmd, cmd_next;
    logic [3:0]                cmd_out_next;
    logic                      bus_req_next;
    logic                      bus_we_next;
    logic [7:0]                bus_addr_next;
    logic [7:0]                bus_data_next;
    logic                      busy_next;

    logic step_edge;
    logic expiry;
    logic trigger;

    assign step_edge = STEP & ~step_q;
    assign expiry    = (state == IDLE) && ENABLE &&
                       (counter == INTERVAL_WIDTH'(INTERVAL - 1));
    assign trigger   = step_edge | expiry;

    // A trigger seen in IDLE is parked in the pending flag and acted on the
    // following cycle; this extra cycle is what makes the STEP-to-REQ latency
    // two edges and the automatic period INTERVAL+4. A pending request also
    // dominates any edge arriving in the same cycle, so coincident triggers
    // collapse into a single write.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        counter_next = '0;
        cmd_next     = cmd;
        cmd_out_next = CMD_OUT;

        if (state != IDLE && step_edge) begin
            pending_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (pending) begin
                    state_next   = REQ;
                    pending_next = 1'b0;
                end else if (trigger) begin
                    pending_next = 1'b1;
                end else if (ENABLE) begin
                    counter_next = counter + INTERVAL_WIDTH'(1);
                end
            end
            REQ: begin
                if (BUS_GNT) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = RELEASE;
            end
            RELEASE: begin
                cmd_out_next = cmd;
                cmd_next     = (cmd == CMD_LAST) ? CMD_FIRST : cmd + 4'd1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Bus outputs are decoded from the next state so the registered
        // copies line up with the state register.
        bus_req_next  = (state_next == REQ) || (state_next == WRITE);
        bus_we_next   = (state_next == WRITE);
        bus_addr_next = (state_next == WRITE) ? SEG_ADDR : 8'h00;
        bus_data_next = (state_next == WRITE) ? {4'h0, cmd} : 8'h00;
        busy_next     = (state_next != IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            step_q   <= 1'b0;
            pending  <= 1'b0;
            counter  <= '0;
            cmd      <= CMD_FIRST;
            CMD_OUT  <= CMD_FIRST;
            BUS_REQ  <= 1'b0;
            BUS_WE   <= 1'b0;
            BUS_ADDR <= 8'h00;
            BUS_DATA <= 8'h00;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_next;
            step_q   <= STEP;
            pending  <= pending_next;
            counter  <= counter_next;
            cmd      <= cmd_next;
            CMD_OUT  <= cmd_out_next;
            BUS_REQ  <= bus_req_next;
            BUS_WE   <= bus_we_next;
            BUS_ADDR <= bus_addr_next;
            BUS_DATA <= bus_data_next;
            BUSY     <= busy_next;
        end
    end

endmodule

// File: tb/tb_seg_cmd_sequencer.sv
// Scoreboard bench: stimulus pushes expected writes, per-instance monitors pop
// and compare on every BUS_WE pulse (data, address, spacing).
module tb_seg_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_enable, a_step, a_gnt;
    logic       a_req, a_we, a_busy;
    logic [7:0] a_addr, a_data;
    logic [3:0] a_cmd_out;

    logic       b_enable, b_step, b_gnt;
    logic       b_req, b_we, b_busy;
    logic [7:0] b_addr, b_data;
    logic [3:0] b_cmd_out;

    seg_cmd_sequencer #(
        .SEG_ADDR(8'hD0), .INTERVAL(10), .INTERVAL_WIDTH(25),
        .CMD_FIRST(4'h0), .CMD_LAST(4'hF)
    ) dut_a (
        .CLK(clk), .RESET(rst), .ENABLE(a_enable), .STEP(a_step), .BUS_GNT(a_gnt),
        .BUS_REQ(a_req), .BUS_ADDR(a_addr), .BUS_DATA(a_data), .BUS_WE(a_we),
        .CMD_OUT(a_cmd_out), .BUSY(a_busy)
    );

    seg_cmd_sequencer #(
        .SEG_ADDR(8'hD0), .INTERVAL(10), .INTERVAL_WIDTH(25),
        .CMD_FIRST(4'h3), .CMD_LAST(4'h5)
    ) dut_b (
        .CLK(clk), .RESET(rst), .ENABLE(b_enable), .STEP(b_step), .BUS_GNT(b_gnt),
        .BUS_REQ(b_req), .BUS_ADDR(b_addr), .BUS_DATA(b_data), .BUS_WE(b_we),
        .CMD_OUT(b_cmd_out), .BUSY(b_busy)
    );

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int a_writes = 0;
    int b_writes = 0;
    int a_last = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor for instance A: every write must match the head of the queue.
    always @(posedge clk) begin
        #1;
        if (!rst && a_we) begin
            a_writes++;
            if (q_a.size() == 0) begin
                checkOutput("a_unexpected_we", 32'd1, 32'd0);
            end else begin
                e_a = q_a.pop_front();
                checkOutput("a_data", {24'h0, a_data}, {24'h0, e_a.data});
                checkOutput("a_addr", {24'h0, a_addr}, 32'h0000_00D0);
                checkOutput("a_req_in_write", {31'h0, a_req}, 32'd1);
                if (e_a.gap > 0) begin
                    checkOutput("a_gap", cyc - a_last, e_a.gap);
                end
            end
            a_last = cyc;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst && b_we) begin
            b_writes++;
            if (q_b.size() == 0) begin
                checkOutput("b_unexpected_we", 32'd1, 32'd0);
            end else begin
                e_b = q_b.pop_front();
                checkOutput("b_data", {24'h0, b_data}, {24'h0, e_b.data});
                checkOutput("b_addr", {24'h0, b_addr}, 32'h0000_00D0);
            end
        end
    end

    task automatic push_a(input logic [7:0] data, input int gap);
        exp_t e;
        e.data = data;
        e.gap  = gap;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] data);
        exp_t e;
        e.data = data;
        e.gap  = 0;
        q_b.push_back(e);
    endtask

    task automatic step_a_pulse();
        a_step = 1'b1;
        @(negedge clk);
        a_step = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        int n;
        int act;
        int w0;
        logic saw_we;
        logic [7:0] b_exp [5];
        b_exp[0] = 8'h03; b_exp[1] = 8'h04; b_exp[2] = 8'h05;
        b_exp[3] = 8'h03; b_exp[4] = 8'h04;

        rst = 1'b1;
        a_enable = 1'b0; a_step = 1'b0; a_gnt = 1'b1;
        b_enable = 1'b0; b_step = 1'b0; b_gnt = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_req", {31'h0, a_req}, 32'd0);
        checkOutput("rst_we", {31'h0, a_we}, 32'd0);
        checkOutput("rst_addr", {24'h0, a_addr}, 32'd0);
        checkOutput("rst_data", {24'h0, a_data}, 32'd0);
        checkOutput("rst_busy", {31'h0, a_busy}, 32'd0);
        checkOutput("rst_cmd_out_a", {28'h0, a_cmd_out}, 32'd0);
        checkOutput("rst_cmd_out_b", {28'h0, b_cmd_out}, 32'd3);

        // Narrow range 3..5 driven by manual steps, 20 cycles apart.
        for (int i = 0; i < 5; i++) begin
            push_b(b_exp[i]);
            b_step = 1'b1;
            @(negedge clk);
            b_step = 1'b0;
            repeat (19) @(negedge clk);
        end
        checkOutput("b_write_count", b_writes, 32'd5);
        checkOutput("b_cmd_out", {28'h0, b_cmd_out}, 32'd4);
        checkOutput("b_queue_empty", q_b.size(), 32'd0);

        // Quiet period: nothing may happen with ENABLE=0 and no STEP.
        act = 0;
        repeat (1000) begin
            @(negedge clk);
            if (a_req || a_we || a_busy) act++;
        end
        checkOutput("idle_activity", act, 32'd0);
        checkOutput("idle_cmd_out", {28'h0, a_cmd_out}, 32'd0);

        // Automatic stepping: 00..0F then wrap to 00, 14 cycles apart.
        for (int i = 0; i < 17; i++) begin
            push_a(8'(i % 16), (i == 0) ? 0 : 14);
        end
        a_enable = 1'b1;
        n = 0;
        while (a_writes < 17 && n < 400) begin
            @(negedge clk);
            n++;
        end
        a_enable = 1'b0;
        checkOutput("interval_writes", a_writes, 32'd17);
        repeat (3) @(negedge clk);
        checkOutput("wrap_cmd_out", {28'h0, a_cmd_out}, 32'd0);
        repeat (30) @(negedge clk);
        checkOutput("disable_no_write", a_writes, 32'd17);

        // Grant withheld: request must hold with no strobe.
        a_gnt = 1'b0;
        push_a(8'h01, 0);
        step_a_pulse();
        n = 0;
        while (!a_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_rise", {31'h0, a_req}, 32'd1);
        act = 0;
        repeat (50) begin
            @(negedge clk);
            if (!a_req || a_we) act++;
        end
        checkOutput("gnt_wait_hold", act, 32'd0);
        a_gnt = 1'b1;
        @(negedge clk);
        checkOutput("gnt_to_we", {31'h0, a_we}, 32'd1);
        repeat (5) @(negedge clk);

        // Extra STEP edges while busy collapse into a single follow-up write.
        a_gnt = 1'b0;
        w0 = a_writes;
        push_a(8'h02, 0);
        push_a(8'h03, 4);
        repeat (4) step_a_pulse();
        a_gnt = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("pending_write_count", a_writes - w0, 32'd2);
        checkOutput("pending_queue_empty", q_a.size(), 32'd0);

        // Reset during the write cycle.
        push_a(8'h04, 0);
        step_a_pulse();
        n = 0;
        saw_we = 1'b0;
        while (!saw_we && n < 20) begin
            @(posedge clk);
            #2;
            saw_we = a_we;
            n++;
        end
        checkOutput("we_before_reset", {31'h0, saw_we}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_we", {31'h0, a_we}, 32'd0);
        checkOutput("async_req", {31'h0, a_req}, 32'd0);
        checkOutput("async_addr", {24'h0, a_addr}, 32'd0);
        checkOutput("async_cmd_out", {28'h0, a_cmd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        w0 = a_writes;
        push_a(8'h00, 0);
        @(negedge clk);
        step_a_pulse();
        repeat (10) @(negedge clk);
        checkOutput("post_reset_write", a_writes - w0, 32'd1);
        checkOutput("post_reset_queue", q_a.size(), 32'd0);
    endtask

    initial begin
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_cmd_sequencer.md
# seg_cmd_sequencer

Bus master that generates the 4-bit command stream for the bus-mapped seven-segment display peripheral. It steps through a command range on a programmable interval, or on a manual STEP pulse. For each command it requests the shared 8-bit bus, issues one single-cycle write to the display's address, then releases the bus. It sits directly upstream of the seven-segment peripheral and shares the bus with the processor through a request/grant handshake.

## Interface
Parameters:
- SEG_ADDR, 8'hD0, bus address of the seven-segment peripheral
- INTERVAL, 25_000_000, CLK cycles between automatic writes (0.25 s at 100 MHz); legal range 2..2^INTERVAL_WIDTH-1
- INTERVAL_WIDTH, 25, interval counter width
- CMD_FIRST, 4'h0, first command of the sequence
- CMD_LAST, 4'hF, last command before wrap; CMD_LAST >= CMD_FIRST

Ports:
- CLK  in  1  system clock, 100 MHz
- RESET  in  1  asynchronous, active-high reset
- ENABLE  in  1  1 = automatic stepping on INTERVAL; 0 = interval counter held at 0
- STEP  in  1  synchronous manual-advance request; acts on its rising edge
- BUS_GNT  in  1  bus grant from the arbiter
- BUS_REQ  out  1  bus request
- BUS_ADDR  out  8  bus address; SEG_ADDR during the write cycle, else 8'h00
- BUS_DATA  out  8  {4'h0, cmd} during the write cycle, else 8'h00
- BUS_WE  out  1  write strobe, exactly one cycle per write
- CMD_OUT  out  4  last command written (status)
- BUSY  out  1  high in any state other than IDLE

## Operation
- All outputs are registered.
- Reset values: BUS_REQ=0, BUS_ADDR=0, BUS_DATA=0, BUS_WE=0, BUSY=0, CMD_OUT=CMD_FIRST. Internal state: cmd=CMD_FIRST, counter=0, pending=0, state=IDLE.
- RESET asserted mid-operation clears everything asynchronously, including a write cycle in flight; the bus is released immediately.
- Trigger is the logical OR of:
  - STEP rising edge, detected against a registered copy of STEP;
  - interval expiry: counter == INTERVAL-1 while ENABLE=1 in IDLE.
- Triggers that coincide in the same cycle produce one write.
- The counter increments only in IDLE with ENABLE=1. It clears on expiry, on any trigger, and while ENABLE=0. The interval is therefore measured from the return to IDLE.
- A STEP edge outside IDLE sets a one-deep pending flag; further edges while pending=1 are dropped. Interval expiry cannot occur outside IDLE.
- State machine:
  - IDLE -> REQ on trigger or pending=1 (pending clears).
  - REQ: BUS_REQ=1; stays in REQ until BUS_GNT is sampled 1, then -> WRITE. There is no timeout.
  - WRITE (one cycle): BUS_REQ=1, BUS_WE=1, BUS_ADDR=SEG_ADDR, BUS_DATA={4'h0,cmd}; -> RELEASE unconditionally. A BUS_GNT drop during WRITE is ignored.
  - RELEASE: BUS_REQ=0, BUS_WE=0, bus outputs return to 0; CMD_OUT<=cmd; cmd<=(cmd==CMD_LAST)?CMD_FIRST:cmd+1; -> IDLE.
- Command arithmetic is 4-bit. Wrap happens only at CMD_LAST, never through 4'hF overflow unless CMD_LAST=4'hF.

## Timing
- STEP rising edge sampled at edge k: BUS_REQ=1 after edge k+1.
- GNT already high: WRITE outputs valid after edge k+2 for exactly one cycle; RELEASE after k+3; IDLE after k+4.
- Minimum spacing between BUS_WE pulses is 4 cycles.
- Each cycle of GNT wait adds one cycle of latency.
- With ENABLE=1 and no STEP, successive BUS_WE pulses are INTERVAL+4 cycles apart (GNT held high).
- CMD_OUT updates one cycle after BUS_WE falls.

## Test plan
- Reset then idle with ENABLE=0, STEP=0, GNT=1 for 1000 cycles -> no BUS_REQ/BUS_WE activity; CMD_OUT=0, BUSY=0.
- INTERVAL=10, ENABLE=1, GNT tied 1 -> BUS_WE pulses 14 cycles apart with BUS_ADDR=8'hD0 and BUS_DATA 00,01,...,0F,00; the wrap after 0F is checked.
- CMD_FIRST=3, CMD_LAST=5, STEP pulsed 5 times, 20 cycles apart -> written data 03,04,05,03,04.
- GNT held 0 for 50 cycles after BUS_REQ rises -> BUS_REQ stays 1 and BUS_WE stays 0 throughout; write occurs 1 cycle after GNT is sampled 1.
- Three STEP edges during one busy write -> exactly one extra write follows, starting 1 cycle after return to IDLE.
- RESET asserted during the WRITE cycle -> BUS_WE, BUS_REQ and BUS_ADDR drop asynchronously; CMD_OUT=CMD_FIRST; the next STEP writes CMD_FIRST.
